dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - port 0: the core load/store unit
  - port 1: the DMA/debug loader
- After reset, and on demand, it runs a clear engine that zeroes the memory one word per cycle. This replaces any bulk in-memory reset.
- Sits between the requesters and the data memory's WE/address/write_data/RD pins. The memory has a combinational read.

---
 rtl/dmem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// ------------
// Shares a single-port, combinational-read data memory between two
// requesters (port 0: core load/store unit, port 1: DMA/debug loader).
// After reset, and whenever clr_req pulses, a clear engine zeroes the
// memory one word per cycle before any requester is served.
//
// Optional feature macro: DMEM_ARB_BOUNDS_EN
//   defined   -> err0/err1 outputs exist; a granted access with
//                addr >= DEPTH is still granted, but it cannot write
//                memory or return read data. Instead err_x pulses on the
//                edge after the grant.
//   undefined -> no err ports; addresses are passed through unchanged.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   clr_req                   one-cycle pulse, restarts the clear sweep
//   busy                      high while the clear sweep runs
//   reqN/weN/addrN/wdataN     requester N access (held until gntN)
//   gntN                      combinational grant for requester N
//   rvalidN/rdataN            registered read response, one cycle after gntN
//   errN                      (bounds option only) out-of-range pulse
//   mem_we/mem_addr/mem_wdata memory write enable, address, write data
//   mem_rdata                 memory read data (combinational from mem_addr)

module dmem_arbiter #(
  parameter int DEPTH  = 4000,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [31:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [31:0]       rdata1,
`ifdef DMEM_ARB_BOUNDS_EN
  output logic              err0,
  output logic              err1,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  clr_ptr_reg, clr_ptr_next;
  // Port that won the most recent grant; the other one wins a tie.
  logic              rr_last_reg, rr_last_next;

  // Per-port views of the requester inputs so both ports share one code path.
  logic [1:0]        req_v;
  logic [1:0]        we_v;
  logic [ADDR_W-1:0] addr_v [2];
  logic [31:0]       wdata_v [2];
  logic [1:0]        in_range;
  logic [1:0]        gnt_v;

  assign req_v      = {req1, req0};
  assign we_v       = {we1, we0};
  assign addr_v[0]  = addr0;
  assign addr_v[1]  = addr1;
  assign wdata_v[0] = wdata0;
  assign wdata_v[1] = wdata1;

  assign gnt0 = gnt_v[0];
  assign gnt1 = gnt_v[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_range
`ifdef DMEM_ARB_BOUNDS_EN
      assign in_range[gi] = (addr_v[gi] < ADDR_W'(DEPTH));
`else
      assign in_range[gi] = 1'b1;
`endif
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      rr_last_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
      rr_last_reg <= rr_last_next;
    end
  end

  // Next state, grants and memory pin drive
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    rr_last_next = rr_last_reg;
    gnt_v        = 2'b00;
    busy         = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_reg)
      CLEAR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = ADDR_W'(clr_ptr_reg);
        if (clr_req) begin
          clr_ptr_next = '0;
        end else if (clr_ptr_reg == LAST_PTR) begin
          clr_ptr_next = '0;
          state_next   = ARB;
        end else begin
          clr_ptr_next = clr_ptr_reg + 1'b1;
        end
      end

      ARB: begin
        if (clr_req) begin
          // A clear request pre-empts every pending access this cycle.
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end else begin
          gnt_v[0] = req_v[0] & (~req_v[1] | rr_last_reg);
          gnt_v[1] = req_v[1] & (~req_v[0] | ~rr_last_reg);
          if (gnt_v[0]) begin
            rr_last_next = 1'b0;
            mem_addr     = addr_v[0];
            mem_wdata    = wdata_v[0];
            mem_we       = we_v[0] & in_range[0];
          end else if (gnt_v[1]) begin
            rr_last_next = 1'b1;
            mem_addr     = addr_v[1];
            mem_wdata    = wdata_v[1];
            mem_we       = we_v[1] & in_range[1];
          end
        end
      end

      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  // Per-port registered read response (and error pulse when enabled).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic        rvalid_reg;
      logic [31:0] rdata_reg;
      logic        rd_done;

      assign rd_done = gnt_v[gi] & ~we_v[gi] & in_range[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= rd_done;
          // rdata only moves on a completed read, so it holds between reads.
          if (rd_done) begin
            rdata_reg <= mem_rdata;
          end
        end
      end

`ifdef DMEM_ARB_BOUNDS_EN
      logic err_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          err_reg <= 1'b0;
        end else begin
          err_reg <= gnt_v[gi] & ~in_range[gi];
        end
      end
`endif
    end
  endgenerate

  assign rvalid0 = g_port[0].rvalid_reg;
  assign rdata0  = g_port[0].rdata_reg;
  assign rvalid1 = g_port[1].rvalid_reg;
  assign rdata1  = g_port[1].rdata_reg;
`ifdef DMEM_ARB_BOUNDS_EN
  assign err0 = g_port[0].err_reg;
  assign err1 = g_port[1].err_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter with a small (DEPTH=8) memory model attached.

module tb_dmem_arbiter;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              clr_req;
  logic              busy;
  logic              req0, we0, gnt0, rvalid0;
  logic [ADDR_W-1:0] addr0;
  logic [31:0]       wdata0, rdata0;
  logic              req1, we1, gnt1, rvalid1;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       wdata1, rdata1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
`ifdef DMEM_ARB_BOUNDS_EN
  logic              err0, err1;
`endif

  dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef DMEM_ARB_BOUNDS_EN
    .err0(err0), .err1(err1),
`endif
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the arbiter: combinational read, synchronous write.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we && (mem_addr < 32'(DEPTH))) ram[mem_addr[2:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? ram[mem_addr[2:0]] : 32'hBAD0_BAD0;

  // Expected memory contents, maintained from the stimulus alone.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        pend0, pend1, perr0, perr1;

  int n_checks;
  int n_pass;

  typedef struct {
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        clr;
    logic        exp_gnt0, exp_gnt1;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                              input logic [31:0] d0, input logic r1, input logic w1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic clr, input logic g0, input logic g1);
    vec_t v;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.clr = clr; v.exp_gnt0 = g0; v.exp_gnt1 = g1;
    return v;
  endfunction

  function automatic logic inr(input logic [31:0] a);
`ifdef DMEM_ARB_BOUNDS_EN
    return a < 32'(DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Registered per-port outputs produced by the previous cycle.
  task automatic check_port_outs();
    check("rvalid0", 32'(rvalid0), 32'(pend0));
    if (pend0 && q0.size() > 0) check("rdata0", rdata0, q0.pop_front());
    check("rvalid1", 32'(rvalid1), 32'(pend1));
    if (pend1 && q1.size() > 0) check("rdata1", rdata1, q1.pop_front());
`ifdef DMEM_ARB_BOUNDS_EN
    check("err0", 32'(err0), 32'(perr0));
    check("err1", 32'(err1), 32'(perr1));
`endif
    pend0 = 1'b0; pend1 = 1'b0; perr0 = 1'b0; perr1 = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    req0 = v.req0; we0 = v.we0; addr0 = v.addr0; wdata0 = v.wdata0;
    req1 = v.req1; we1 = v.we1; addr1 = v.addr1; wdata1 = v.wdata1;
    clr_req = v.clr;
    #1;
    check_port_outs();
    check("gnt0", 32'(gnt0), 32'(v.exp_gnt0));
    check("gnt1", 32'(gnt1), 32'(v.exp_gnt1));
    check("busy", 32'(busy), 32'd0);
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (v.exp_gnt0) begin
      e_we = v.we0 & inr(v.addr0); e_addr = v.addr0; e_wdata = v.wdata0;
    end else if (v.exp_gnt1) begin
      e_we = v.we1 & inr(v.addr1); e_addr = v.addr1; e_wdata = v.wdata1;
    end
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    if (v.exp_gnt0) begin
      pend0 = ~v.we0 & inr(v.addr0);
      perr0 = ~inr(v.addr0);
      if (pend0) q0.push_back(ref_mem[v.addr0[2:0]]);
    end
    if (v.exp_gnt1) begin
      pend1 = ~v.we1 & inr(v.addr1);
      perr1 = ~inr(v.addr1);
      if (pend1) q1.push_back(ref_mem[v.addr1[2:0]]);
    end
    if (e_we) ref_mem[e_addr[2:0]] = e_wdata;
    $display("t=%0t req=%b%b we=%b%b clr=%b gnt=%b%b mem_we=%b addr=%0d wdata=%h",
             $time, v.req1, v.req0, v.we1, v.we0, v.clr, gnt1, gnt0, mem_we, mem_addr, mem_wdata);
  endtask

  task automatic sweep(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clr_req = 1'b0;
      #1;
      check_port_outs();
      check("sweep_busy", 32'(busy), 32'd1);
      check("sweep_we", 32'(mem_we), 32'd1);
      check("sweep_addr", mem_addr, 32'(start + i));
      check("sweep_wdata", mem_wdata, 32'd0);
      check("sweep_gnt", 32'({gnt1, gnt0}), 32'd0);
    end
    if (start == 0 && n == DEPTH) begin
      for (int j = 0; j < DEPTH; j++) ref_mem[j] = '0;
    end
    $display("t=%0t sweep of %0d words from %0d", $time, n, start);
  endtask

  vec_t idle;

  initial begin
    n_checks = 0; n_pass = 0;
    pend0 = 0; pend1 = 0; perr0 = 0; perr1 = 0;
    for (int j = 0; j < DEPTH; j++) ref_mem[j] = 32'hFFFF_FFFF;
    rst = 1'b0; clr_req = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,            0, 1, 0);
    tbl[1]  = mk(1, 0, 5, 0,            0, 0, 0, 0,            0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,            1, 1, 2, 32'h12345678, 0, 0, 1);
    tbl[4]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            0, 1, 0);
    tbl[5]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            0, 0, 1);
    tbl[6]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            0, 1, 0);
    tbl[7]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            0, 0, 1);
    tbl[8]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            0, 1, 0);
    tbl[9]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            0, 0, 1);
    tbl[10] = mk(1, 1, 3, 32'h0A0A0A0A, 1, 1, 4, 32'h0B0B0B0B, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0,            1, 1, 4, 32'h0B0B0B0B, 0, 0, 1);
    tbl[12] = mk(1, 0, 4, 0,            1, 0, 3, 0,            0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0,            1, 0, 3, 0,            0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0);

    // Reset state, then the power-on sweep.
    repeat (2) @(posedge clk);
    #2;
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    sweep(DEPTH, 0);

    // Table: writes, reads, alternation under contention.
    for (int i = 0; i < 15; i++) apply(tbl[i]);
    apply(idle);
    check("rdata0_hold", rdata0, 32'h0B0B0B0B);
    check("rdata1_hold", rdata1, 32'h0A0A0A0A);

    // clr_req with port 1 waiting, plus a restart mid-clear.
    apply(mk(0, 0, 0, 0, 1, 0, 5, 0, 1, 0, 0));
    sweep(2, 0);
    @(negedge clk);
    clr_req = 1'b1;
    #1;
    check("clr_in_clear_addr", mem_addr, 32'd2);
    sweep(DEPTH, 0);
    apply(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 1));
    apply(idle);

`ifdef DMEM_ARB_BOUNDS_EN
    apply(mk(1, 1, DEPTH, 32'h77, 0, 0, 0, 0, 0, 1, 0));
    apply(idle);
    apply(idle);
`endif

    // Reset while a read response is pending.
    apply(mk(1, 1, 6, 32'h66, 0, 0, 0, 0, 0, 1, 0));
    apply(mk(1, 0, 6, 0,      0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    #1;
    check_port_outs();
    rst = 1'b0;
    #1;
    check("midgrant_rvalid0", 32'(rvalid0), 32'd0);
    check("midgrant_rdata0", rdata0, 32'd0);
    check("midgrant_busy", 32'(busy), 32'd1);
    q0.delete(); q1.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    sweep(DEPTH, 0);

    // Reset in the middle of a sweep.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    sweep(3, 0);
    @(negedge clk);
    #1;
    check("midsweep_addr3", mem_addr, 32'd3);
    rst = 1'b0;
    #1;
    check("midsweep_rst_addr", mem_addr, 32'd0);
    check("midsweep_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    sweep(DEPTH, 0);

    // rr_last returns to 1 on reset, so port 0 wins the first contest.
    apply(mk(1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 0));
    apply(idle);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
